// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: opcodes, functs,
// ALU operations, datapath select codes and the controller state set.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;

    localparam logic       SRC_A_PC     = 1'b0;
    localparam logic       SRC_A_REG    = 1'b1;
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH2 = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MDR  = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DCD     = 4'd1,
        EXE_R   = 4'd2,
        WB_R    = 4'd3,
        EXE_I   = 4'd4,
        WB_I    = 4'd5,
        MEM_ADR = 4'd6,
        MEM_RD  = 4'd7,
        MEM_WR  = 4'd8,
        WB_LW   = 4'd9,
        BRANCH  = 4'd10,
        JUMP    = 4'd11,
        JR      = 4'd12,
        JAL     = 4'd13
    } state_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// enables and selects out.
interface mc_ctrl_fsm_if;
    import mc_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ov;
    logic       pc_we;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
    logic       ov_flag;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, ov,
        output pc_we, ir_we, mem_we, reg_we, alu_src_a, alu_src_b, alu_op,
               ext_op, reg_dst, mem_to_reg, pc_src, illegal, ov_flag, state
    );

    modport slave (
        output opcode, funct, zero, ov,
        input  pc_we, ir_we, mem_we, reg_we, alu_src_a, alu_src_b, alu_op,
               ext_op, reg_dst, mem_to_reg, pc_src, illegal, ov_flag, state
    );

endinterface

// File: rtl/mc_alu_ctrl.sv
// ALU operation and immediate-extension select, decoded from controller
// state and the instruction fields.
module mc_alu_ctrl
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op
);

    always_comb begin
        alu_op = ALU_ADD;
        ext_op = EXT_ZERO;
        case (state)
            DCD, MEM_ADR: ext_op = EXT_SIGN;
            BRANCH:       alu_op = ALU_SUB;
            EXE_R: begin
                case (funct)
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            EXE_I: begin
                // lui adds the shifted immediate to $0, so it stays on ALU_ADD
                case (opcode)
                    OP_ADDI: ext_op = EXT_SIGN;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_LUI:  ext_op = EXT_LUI;
                    default: ext_op = EXT_ZERO;
                endcase
            end
            default: begin
                alu_op = ALU_ADD;
                ext_op = EXT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM driving PC/IR/regfile/memory
// enables and datapath selects.
//
//   state   | meaning
//   FETCH   | IR <= mem[PC], PC <= PC+4
//   DCD     | read regs, ALUOut <= branch target, dispatch on opcode/funct
//   EXE_R   | ALUOut <= A op B
//   WB_R    | rd <= ALUOut
//   EXE_I   | ALUOut <= A op ext(imm), capture addi overflow
//   WB_I    | rt <= ALUOut unless suppressed by overflow
//   MEM_ADR | ALUOut <= A + sext(imm)
//   MEM_RD  | MDR <= mem[ALUOut]
//   MEM_WR  | mem[ALUOut] <= B
//   WB_LW   | rt <= MDR
//   BRANCH  | compare A-B, PC <= ALUOut if zero
//   JUMP    | PC <= jump target
//   JR      | PC <= A
//   JAL     | PC <= jump target, $31 <= PC
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter bit OV_SUPPRESS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    state_t     state_q, state_d;
    logic       ov_q;
    logic [2:0] alu_op_c;
    logic [1:0] ext_op_c;

    mc_alu_ctrl u_alu_ctrl (
        .state  (state_q),
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .alu_op (alu_op_c),
        .ext_op (ext_op_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ov_q    <= (state_q == EXE_I) && bus.ov && (bus.opcode == OP_ADDI);
        end
    end

    always_comb begin
        state_d        = FETCH;
        bus.pc_we      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.mem_we     = 1'b0;
        bus.reg_we     = 1'b0;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_REG;
        bus.reg_dst    = DST_RT;
        bus.mem_to_reg = M2R_ALU;
        bus.pc_src     = PC_ALU;
        bus.illegal    = 1'b0;
        bus.ov_flag    = 1'b0;
        // outputs are forced quiet for the whole reset cycle
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    bus.ir_we     = 1'b1;
                    bus.pc_we     = 1'b1;
                    bus.alu_src_b = SRC_B_FOUR;
                    state_d       = DCD;
                end
                DCD: begin
                    bus.alu_src_b = SRC_B_IMMSH2;
                    case (bus.opcode)
                        OP_RTYPE: begin
                            case (bus.funct)
                                FN_ADDU, FN_SUBU, FN_SLT: state_d = EXE_R;
                                FN_JR:   state_d = JR;
                                default: bus.illegal = 1'b1;
                            endcase
                        end
                        OP_ADDI, OP_ORI, OP_LUI: state_d = EXE_I;
                        OP_LW, OP_SW:            state_d = MEM_ADR;
                        OP_BEQ:                  state_d = BRANCH;
                        OP_J:                    state_d = JUMP;
                        OP_JAL:                  state_d = JAL;
                        default:                 bus.illegal = 1'b1;
                    endcase
                end
                EXE_R: begin
                    bus.alu_src_a = SRC_A_REG;
                    state_d       = WB_R;
                end
                WB_R: begin
                    bus.reg_dst = DST_RD;
                    bus.reg_we  = 1'b1;
                end
                EXE_I: begin
                    bus.alu_src_a = SRC_A_REG;
                    bus.alu_src_b = SRC_B_IMM;
                    state_d       = WB_I;
                end
                WB_I: begin
                    bus.reg_we  = !(OV_SUPPRESS && ov_q);
                    bus.ov_flag = ov_q;
                end
                MEM_ADR: begin
                    bus.alu_src_a = SRC_A_REG;
                    bus.alu_src_b = SRC_B_IMM;
                    state_d       = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_WR:  bus.mem_we = 1'b1;
                MEM_RD:  state_d    = WB_LW;
                WB_LW: begin
                    bus.mem_to_reg = M2R_MDR;
                    bus.reg_we     = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a = SRC_A_REG;
                    bus.pc_src    = PC_ALUOUT;
                    bus.pc_we     = bus.zero;
                end
                JUMP: begin
                    bus.pc_src = PC_JUMP;
                    bus.pc_we  = 1'b1;
                end
                JR: begin
                    bus.pc_src = PC_REG;
                    bus.pc_we  = 1'b1;
                end
                JAL: begin
                    bus.pc_src     = PC_JUMP;
                    bus.pc_we      = 1'b1;
                    bus.reg_dst    = DST_RA;
                    bus.mem_to_reg = M2R_PC;
                    bus.reg_we     = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign bus.alu_op = rst ? ALU_ADD : alu_op_c;
    assign bus.ext_op = rst ? EXT_ZERO : ext_op_c;
    assign bus.state  = state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS main controller: Moore FSM sequencing PC, IR, register file, memory and the shared ALU across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK cycles.
- Sits beside the datapath top level; consumes opcode/funct and ALU status flags (zero, OV); drives all write enables, mux selects and the 3-bit ALU operation code.
- Supported instructions: addu, subu, slt, jr (R-type); addi, ori, lui, lw, sw, beq, j, jal.

Parameters:
- OV_SUPPRESS, 1, when 1 an addi that overflows does not write the register file.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result==0, combinational from ALU
- ov  in  1  ALU overflow; meaningful only when ALU executes addi
- pc_we  out  1  PC write enable (already qualified with zero for beq)
- ir_we  out  1  instruction register load
- mem_we  out  1  data memory write
- reg_we  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A register (rs)
- alu_src_b  out  2  00=B register (rt), 01=constant 4, 10=extended imm, 11=extended imm<<2
- alu_op  out  3  000 add, 001 sub, 010 or, 011 and, 100 slt (signed)
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],imm26,2'b0}, 11 A register (jr)
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- ov_flag  out  1  one-cycle pulse when addi overflow was detected
- state  out  4  current state encoding (debug/verification)

Behaviour:
- Reset: while rst=1 every enable (pc_we, ir_we, mem_we, reg_we), illegal and ov_flag = 0; all selects/alu_op = 0; on the edge with rst=1 state <= FETCH. rst mid-instruction abandons it; no partial write issues after the reset edge.
- Outputs are pure functions of state (plus opcode/funct/zero where noted); only the state register and ov_q are sequential.
- FETCH: ir_we=1; alu_src_a=0, alu_src_b=01, alu_op=000; pc_src=00, pc_we=1 -> DCD.
- DCD: alu_src_a=0, alu_src_b=11, ext_op=01, alu_op=000 (branch target into ALUOut). Next: R-type addu/subu/slt -> EXE_R; jr -> JR; addi/ori/lui -> EXE_I; lw/sw -> MEM_ADR; beq -> BRANCH; j -> JUMP; jal -> JAL; anything else -> illegal=1, FETCH.
- EXE_R: alu_src_a=1, alu_src_b=00, alu_op per funct (addu 000, subu 001, slt 100) -> WB_R.
- WB_R: reg_dst=01, mem_to_reg=00, reg_we=1 -> FETCH.
- EXE_I: alu_src_a=1, alu_src_b=10; addi: ext_op=01, alu_op=000; ori: ext_op=00, alu_op=010; lui: ext_op=10, alu_op=010 with A forced by datapath? No: lui uses alu_op=000 with alu_src_a=1 and rs=$0 per ISA encoding. ov_q <= ov & (opcode==addi) -> WB_I.
- WB_I: reg_dst=00, mem_to_reg=00; reg_we = !(OV_SUPPRESS & ov_q); ov_flag = ov_q -> FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=10, ext_op=01, alu_op=000 -> MEM_RD (lw) / MEM_WR (sw).
- MEM_WR: mem_we=1 -> FETCH. MEM_RD: MDR loads (datapath, unconditional) -> WB_LW. WB_LW: reg_dst=00, mem_to_reg=01, reg_we=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_we=zero -> FETCH.
- JUMP: pc_src=10, pc_we=1 -> FETCH. JR: pc_src=11, pc_we=1 -> FETCH.
- JAL: pc_src=10, pc_we=1, reg_dst=10, mem_to_reg=10, reg_we=1 (PC already +4) -> FETCH.
- Latencies (cycles): beq/j/jr/jal 3, R-type/I-ALU/sw 4, lw 5.
- Any unreachable state encoding -> FETCH next cycle, all enables 0.

Decomposition:
- Shared package mc_pkg: opcode/funct constants, ALU op codes (000..100), select encodings for src/dst/pc_src/ext, state enumeration.
- One sub-module: mc_alu_ctrl (combinational: state, opcode, funct -> alu_op, ext_op); FSM remains in mc_ctrl_fsm.

Test Plan:
- rst=1 for 2 cycles while opcode=lw -> all enables 0, state=FETCH after release; first cycle shows ir_we=1, pc_we=1, alu_src_b=01.
- addu (opcode 000000, funct 100001) -> FETCH,DCD,EXE_R,WB_R; alu_op=000 in EXE_R; reg_we=1 reg_dst=01 only in WB_R.
- lw then sw -> 5 and 4 cycles; mem_we=1 only in MEM_WR, reg_we=1 with mem_to_reg=01 only in WB_LW.
- beq with zero=1 vs zero=0 -> BRANCH cycle pc_we=1/0, pc_src=01, alu_op=001; 3 cycles each.
- addi with ov=1 in EXE_I -> WB_I reg_we=0, ov_flag=1; with OV_SUPPRESS=0 -> reg_we=1, ov_flag=1; ov=1 on ori -> ov_flag=0.
- opcode 111111 -> illegal=1 in DCD, next state FETCH, no writes; jal -> reg_dst=10, mem_to_reg=10, pc_src=10, reg_we=pc_we=1 in one cycle.
